// File: rtl/wb_mux_reg.sv
// wb_mux_reg: registered Wishbone single-master, N-slave address decoder and data mux with timeout
module wb_mux_reg #(
    parameter int                    NSLAVES      = 6,
    parameter int                    AW           = 32,
    parameter int                    DW           = 32,
    parameter logic [NSLAVES*AW-1:0] MATCH_ADDR   = '0,
    parameter logic [NSLAVES*AW-1:0] MATCH_MASK   = '0,
    parameter int                    TMOBITS      = 8,
    parameter int                    TIMEOUT      = 255,
    parameter bit                    UNMAPPED_ERR = 1'b1,
    parameter logic [DW-1:0]         DEFAULT_DATA = {DW{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AW-1:0]           m_adr_i,
    input  logic [DW-1:0]           m_dat_i,
    output logic [DW-1:0]           m_dat_o,
    input  logic                    m_we_i,
    input  logic [DW/8-1:0]         m_sel_i,
    input  logic                    m_stb_i,
    input  logic                    m_cyc_i,
    output logic                    m_ack_o,
    output logic                    m_err_o,
    output logic                    m_rty_o,
    output logic [NSLAVES*AW-1:0]   s_adr_o,
    output logic [NSLAVES*DW-1:0]   s_dat_o,
    input  logic [NSLAVES*DW-1:0]   s_dat_i,
    output logic [NSLAVES-1:0]      s_we_o,
    output logic [NSLAVES*DW/8-1:0] s_sel_o,
    output logic [NSLAVES-1:0]      s_stb_o,
    output logic [NSLAVES-1:0]      s_cyc_o,
    input  logic [NSLAVES-1:0]      s_ack_i,
    input  logic [NSLAVES-1:0]      s_err_i,
    input  logic [NSLAVES-1:0]      s_rty_i,
    output logic                    timeout_o,
    output logic [15:0]             err_count_o
);
    localparam int IW = NSLAVES > 1 ? $clog2(NSLAVES) : 1;
    localparam int SW = DW / 8;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t             state, state_d;
    logic [AW-1:0]      adr_q;
    logic [DW-1:0]      dat_q;
    logic               we_q;
    logic [SW-1:0]      sel_q;
    logic [IW-1:0]      idx_q;
    logic [TMOBITS-1:0] cnt;
    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic               req, rd, tmo;
    logic               sl_ack, sl_err, sl_rty;
    logic [DW-1:0]      sl_dat;
    logic               rsp_ack, rsp_err, rsp_rty, rsp_tmo;
    assign req    = m_cyc_i && m_stb_i;
    assign sl_ack = s_ack_i[idx_q];
    assign sl_err = s_err_i[idx_q];
    assign sl_rty = s_rty_i[idx_q];
    assign sl_dat = s_dat_i[idx_q*DW +: DW];
    assign tmo    = cnt == TMOBITS'(TIMEOUT - 1);
    assign rd     = state == BUSY ? !we_q : !m_we_i;
    assign s_adr_o = {NSLAVES{adr_q}};
    assign s_dat_o = {NSLAVES{dat_q}};
    assign s_we_o  = {NSLAVES{we_q}};
    assign s_sel_o = {NSLAVES{sel_q}};
    assign s_stb_o = state == BUSY ? NSLAVES'(1) << idx_q : '0;
    assign s_cyc_o = s_stb_o;
    // Address decode: scan downwards so the lowest matching slave wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--)
            if ((m_adr_i & MATCH_MASK[i*AW +: AW]) == (MATCH_ADDR[i*AW +: AW] & MATCH_MASK[i*AW +: AW])) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
    end
    // State register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_d;
    // Next state and the response to be registered at this edge (err > ack > rty > timeout)
    always_comb begin
        state_d = state;
        rsp_ack = 1'b0;
        rsp_err = 1'b0;
        rsp_rty = 1'b0;
        rsp_tmo = 1'b0;
        case (state)
            IDLE: if (req) begin
                state_d = hit ? BUSY : RESP;
                rsp_err = !hit && UNMAPPED_ERR;
                rsp_ack = !hit && !UNMAPPED_ERR;
            end
            BUSY: if (!m_cyc_i) state_d = IDLE;
                else if (sl_err || sl_ack || sl_rty || tmo) begin
                    state_d = RESP;
                    rsp_ack = !sl_err && sl_ack;
                    rsp_rty = !sl_err && !sl_ack && sl_rty;
                    rsp_tmo = !sl_err && !sl_ack && !sl_rty;
                    rsp_err = sl_err || rsp_tmo;
                end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Request latch, timeout counter, registered master response and error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            idx_q       <= '0;
            cnt         <= '0;
            m_dat_o     <= '0;
            m_ack_o     <= 1'b0;
            m_err_o     <= 1'b0;
            m_rty_o     <= 1'b0;
            timeout_o   <= 1'b0;
            err_count_o <= '0;
        end else begin
            if (state == IDLE && req) begin
                adr_q <= m_adr_i;
                dat_q <= m_dat_i;
                we_q  <= m_we_i;
                sel_q <= m_sel_i;
                idx_q <= hit_idx;
            end
            cnt       <= state == BUSY ? cnt + 1'b1 : '0;
            m_ack_o   <= rsp_ack;
            m_err_o   <= rsp_err;
            m_rty_o   <= rsp_rty;
            timeout_o <= rsp_tmo;
            if (rsp_ack && rd) m_dat_o <= state == BUSY ? sl_dat : DEFAULT_DATA;
            if (rsp_err && err_count_o != 16'hffff) err_count_o <= err_count_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_mux_reg.sv
// tb_wb_mux_reg: directed scoreboard bench for wb_mux_reg with both unmapped-address policies
module tb_wb_mux_reg;
    localparam int NS = 6;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam logic [NS*AW-1:0] MA = {32'h2000_0000, 32'h1000_0000, 32'h1000_0000,
                                       32'h0000_0300, 32'h0001_0000, 32'h0000_0200};
    localparam logic [NS*AW-1:0] MM = {32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000,
                                       32'hFFFF_FFFC, 32'hFFFF_0000, 32'hFFFF_FFFC};
    localparam logic [2:0] ACK = 3'b100, ERR = 3'b010, RTY = 3'b001;

    typedef struct {
        logic [2:0]  rsp;
        logic [31:0] dat;
        logic        tmo;
        int          cyc;
    } exp_t;

    logic clk = 0, reset = 1;
    logic [AW-1:0] m_adr = '0;
    logic [DW-1:0] m_dat = '0;
    logic m_we = 0, m_stb = 0, m_cyc = 0;
    logic [SW-1:0] m_sel = '0;
    logic [NS*DW-1:0] s_dat_i;
    logic [NS-1:0] s_ack_i, s_err_i, s_rty_i;

    logic [DW-1:0] dat1, dat0;
    logic ack1, err1, rty1, tmo1, ack0, err0, rty0, tmo0;
    logic [NS*AW-1:0] sadr1, sadr0;
    logic [NS*DW-1:0] sdat1, sdat0;
    logic [NS-1:0] swe1, sstb1, scyc1, swe0, sstb0, scyc0;
    logic [NS*SW-1:0] ssel1, ssel0;
    logic [15:0] ecnt1, ecnt0;

    logic [2:0] mode [NS];
    exp_t q1[$], q0[$];
    exp_t e1, e0;
    int checks = 0, errors = 0, cyc = 0;
    int stb_n [NS];
    int tmo_n = 0;
    logic [31:0] adr_seen, dat_seen;
    logic we_seen;
    logic [SW-1:0] sel_seen;

    wb_mux_reg #(.NSLAVES(NS), .AW(AW), .DW(DW), .MATCH_ADDR(MA), .MATCH_MASK(MM),
                 .TMOBITS(8), .TIMEOUT(4), .UNMAPPED_ERR(1'b1), .DEFAULT_DATA(32'hffffffff)) dut (
        .clk(clk), .reset(reset), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(dat1), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_stb_i(m_stb), .m_cyc_i(m_cyc), .m_ack_o(ack1), .m_err_o(err1), .m_rty_o(rty1),
        .s_adr_o(sadr1), .s_dat_o(sdat1), .s_dat_i(s_dat_i), .s_we_o(swe1), .s_sel_o(ssel1),
        .s_stb_o(sstb1), .s_cyc_o(scyc1), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .timeout_o(tmo1), .err_count_o(ecnt1));

    wb_mux_reg #(.NSLAVES(NS), .AW(AW), .DW(DW), .MATCH_ADDR(MA), .MATCH_MASK(MM),
                 .TMOBITS(8), .TIMEOUT(4), .UNMAPPED_ERR(1'b0), .DEFAULT_DATA(32'hffffffff)) dut0 (
        .clk(clk), .reset(reset), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(dat0), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_stb_i(m_stb), .m_cyc_i(m_cyc), .m_ack_o(ack0), .m_err_o(err0), .m_rty_o(rty0),
        .s_adr_o(sadr0), .s_dat_o(sdat0), .s_dat_i(s_dat_i), .s_we_o(swe0), .s_sel_o(ssel0),
        .s_stb_o(sstb0), .s_cyc_o(scyc0), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .timeout_o(tmo0), .err_count_o(ecnt0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign s_dat_i = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003,
                      32'h2222_0002, 32'h1111_0001, 32'h00AB_CDEF};

    // slave models: mode 0 ack, 1 err, 2 rty, 3 ack+err, 4 silent; respond in the first strobed cycle
    always_comb begin
        s_ack_i = '0;
        s_err_i = '0;
        s_rty_i = '0;
        for (int i = 0; i < NS; i++) begin
            s_ack_i[i] = sstb1[i] && (mode[i] == 3'd0 || mode[i] == 3'd3);
            s_err_i[i] = sstb1[i] && (mode[i] == 3'd1 || mode[i] == 3'd3);
            s_rty_i[i] = sstb1[i] && mode[i] == 3'd2;
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) if (sstb1[i]) stb_n[i]++;
        if (tmo1) tmo_n++;
        if (sstb1[3]) begin
            adr_seen = sadr1[4*AW +: AW];
            dat_seen = sdat1[4*DW +: DW];
            we_seen  = swe1[4];
            sel_seen = ssel1[4*SW +: SW];
        end
    end

    always @(negedge clk) if (!reset && (ack1 || err1 || rty1)) begin
        if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut1_unexpected: got ack/err/rty=%b%b%b expected none", ack1, err1, rty1);
        end else begin
            e1 = q1.pop_front();
            chk("dut1_rsp", {29'b0, ack1, err1, rty1}, {29'b0, e1.rsp});
            chk("dut1_dat", dat1, e1.dat);
            chk("dut1_tmo", {31'b0, tmo1}, {31'b0, e1.tmo});
            chk("dut1_lat", cyc, e1.cyc);
        end
    end

    always @(negedge clk) if (!reset && (ack0 || err0 || rty0)) begin
        if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut0_unexpected: got ack/err/rty=%b%b%b expected none", ack0, err0, rty0);
        end else begin
            e0 = q0.pop_front();
            chk("dut0_rsp", {29'b0, ack0, err0, rty0}, {29'b0, e0.rsp});
            chk("dut0_dat", dat0, e0.dat);
            chk("dut0_tmo", {31'b0, tmo0}, {31'b0, e0.tmo});
            chk("dut0_lat", cyc, e0.cyc);
        end
    end

    task automatic clr();
        for (int i = 0; i < NS; i++) stb_n[i] = 0;
        tmo_n = 0;
    endtask

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wd, input logic [SW-1:0] sel,
                        input logic [2:0] r1, input logic [31:0] d1, input logic [2:0] r0, input logic [31:0] d0,
                        input logic tm, input int lat);
        exp_t e;
        int n;
        @(negedge clk);
        clr();
        m_adr = adr; m_we = we; m_dat = wd; m_sel = sel; m_cyc = 1; m_stb = 1;
        e.tmo = tm; e.cyc = cyc + 1 + lat;
        e.rsp = r1; e.dat = d1; q1.push_back(e);
        e.rsp = r0; e.dat = d0; q0.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (!(ack1 || err1 || rty1) && n < 20);
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL xfer_wait: no response for %h within 20 cycles, required one", adr);
        end
        m_cyc = 0; m_stb = 0; m_we = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NS; i++) mode[i] = 3'd0;
        mode[5] = 3'd4;
        repeat (3) @(negedge clk);
        chk("rst_rsp", {28'b0, ack1, err1, rty1, tmo1}, 0);
        chk("rst_bus", {31'b0, |{sadr1, sdat1, ssel1, swe1, sstb1, scyc1}}, 0);
        chk("rst_dat_ecnt", {dat1[15:0] | ecnt1}, 0);
        reset = 0;
        // zero-wait GPIO read
        xfer(32'h200, 0, 0, 4'hf, ACK, 32'h00AB_CDEF, ACK, 32'h00AB_CDEF, 0, 1);
        chk("gpio_stb_n", stb_n[0], 1);
        chk("gpio_others", stb_n[1] + stb_n[2] + stb_n[3] + stb_n[4] + stb_n[5], 0);
        // write to address matched by slaves 3 and 4; read data must stay put
        xfer(32'h1000_0040, 1, 32'hCAFE_F00D, 4'h5, ACK, 32'h00AB_CDEF, ACK, 32'h00AB_CDEF, 0, 1);
        chk("ovl_stb3", stb_n[3], 1);
        chk("ovl_stb4", stb_n[4], 0);
        chk("bcast_adr", adr_seen, 32'h1000_0040);
        chk("bcast_dat", dat_seen, 32'hCAFE_F00D);
        chk("bcast_we_sel", {27'b0, we_seen, sel_seen}, 32'h15);
        // unmapped read: err on dut, default-data ack on dut0
        xfer(32'h8000_0000, 0, 0, 4'hf, ERR, 32'h00AB_CDEF, ACK, 32'hffff_ffff, 0, 0);
        chk("unm_ecnt1", ecnt1, 1);
        chk("unm_ecnt0", ecnt0, 0);
        chk("unm_stb", stb_n[0] + stb_n[1] + stb_n[2] + stb_n[3] + stb_n[4] + stb_n[5], 0);
        // silent slave: timeout after 4 strobed cycles
        xfer(32'h2000_0010, 0, 0, 4'hf, ERR, 32'h00AB_CDEF, ERR, 32'hffff_ffff, 1, 4);
        chk("tmo_stb_n", stb_n[5], 4);
        @(negedge clk);
        chk("tmo_pulses", tmo_n, 1);
        chk("tmo_ecnt1", ecnt1, 2);
        chk("tmo_ecnt0", ecnt0, 1);
        // ack together with err gives err only
        mode[2] = 3'd3;
        xfer(32'h300, 0, 0, 4'hf, ERR, 32'h00AB_CDEF, ERR, 32'hffff_ffff, 0, 1);
        chk("ackerr_ecnt1", ecnt1, 3);
        // retry only
        mode[1] = 3'd2;
        xfer(32'h0001_0010, 0, 0, 4'hf, RTY, 32'h00AB_CDEF, RTY, 32'hffff_ffff, 0, 1);
        chk("rty_ecnt1", ecnt1, 3);
        mode[1] = 3'd0;
        xfer(32'h0001_0020, 0, 0, 4'hf, ACK, 32'h1111_0001, ACK, 32'h1111_0001, 0, 1);
        // abort mid-BUSY
        @(negedge clk);
        clr();
        m_adr = 32'h2000_0008; m_cyc = 1; m_stb = 1;
        repeat (2) @(negedge clk);
        m_cyc = 0; m_stb = 0;
        @(negedge clk);
        chk("abort_stb", {26'b0, sstb1}, 0);
        chk("abort_cyc", {26'b0, scyc1}, 0);
        chk("abort_stb_n", stb_n[5], 2);
        repeat (6) @(negedge clk);
        chk("abort_ecnt", ecnt1, 3);
        // reset mid-BUSY
        m_adr = 32'h2000_0000; m_cyc = 1; m_stb = 1;
        repeat (2) @(negedge clk);
        chk("pre_rst_stb", {26'b0, sstb1}, 32'h20);
        reset = 1; m_cyc = 0; m_stb = 0;
        @(negedge clk);
        chk("mid_rst_rsp", {24'b0, ack1, err1, rty1, tmo1, ack0, err0, rty0, tmo0}, 0);
        chk("mid_rst_bus1", {31'b0, |{sadr1, sdat1, ssel1, swe1, sstb1, scyc1}}, 0);
        chk("mid_rst_bus0", {31'b0, |{sadr0, sdat0, ssel0, swe0, sstb0, scyc0}}, 0);
        chk("mid_rst_ecnt", {ecnt1, ecnt0}, 0);
        chk("mid_rst_dat", dat1 | dat0, 0);
        reset = 0;
        xfer(32'h200, 0, 0, 4'hf, ACK, 32'h00AB_CDEF, ACK, 32'h00AB_CDEF, 0, 1);
        repeat (3) @(negedge clk);
        chk("sb_empty", q1.size() + q0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_mux_reg.md
Name: wb_mux_reg

Overview:
- Registered Wishbone single-master, N-slave address decoder and data mux.
- Parametrised successor to the combinational wb_mux in the SoC top.
- Adds registered request and response paths, a per-transaction timeout that returns a bus error, and a selectable unmapped-address policy (error or default data).
- Sits between Core's data port and the peripheral and memory slaves, so one hung slave cannot stall the core forever.

Parameters:
- NSLAVES, 6, number of slave ports.
- AW, 32, address width.
- DW, 32, data width (byte selects = DW/8).
- MATCH_ADDR, {NSLAVES{AW'h0}}, concatenated per-slave match address; slave 0 occupies the LSBs.
- MATCH_MASK, {NSLAVES{AW'h0}}, concatenated per-slave mask.
- TMOBITS, 8, timeout counter width.
- TIMEOUT, 255, cycles waited in BUSY before forcing an error; must be ≥1 and < 2^TMOBITS.
- UNMAPPED_ERR, 1, 1 = unmapped access ends in err; 0 = unmapped access ends in ack with DEFAULT_DATA.
- DEFAULT_DATA, 32'hffffffff, read data returned on an unmapped ack.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- m_adr_i  in  AW  master address.
- m_dat_i  in  DW  master write data.
- m_dat_o  out  DW  read data to master.
- m_we_i  in  1  write enable.
- m_sel_i  in  DW/8  byte selects.
- m_stb_i  in  1  strobe.
- m_cyc_i  in  1  cycle.
- m_ack_o  out  1  acknowledge.
- m_err_o  out  1  error.
- m_rty_o  out  1  retry.
- s_adr_o  out  NSLAVES*AW  per-slave address (broadcast copy).
- s_dat_o  out  NSLAVES*DW  per-slave write data (broadcast).
- s_dat_i  in  NSLAVES*DW  per-slave read data.
- s_we_o  out  NSLAVES  per-slave write enable (broadcast).
- s_sel_o  out  NSLAVES*DW/8  per-slave byte selects (broadcast).
- s_stb_o  out  NSLAVES  per-slave strobe (selected slave only).
- s_cyc_o  out  NSLAVES  per-slave cycle (selected slave only).
- s_ack_i  in  NSLAVES  per-slave acknowledge.
- s_err_i  in  NSLAVES  per-slave error.
- s_rty_i  in  NSLAVES  per-slave retry.
- timeout_o  out  1  one-cycle pulse when a timeout fires.
- err_count_o  out  16  saturating count of errors returned to the master.

Behaviour:
- Decode:
  - Slave i matches when (m_adr_i & MASK[i]) == (MATCH[i] & MASK[i]).
  - The lowest matching index wins.
  - No match means unmapped.
- States: IDLE, BUSY, RESP.
- IDLE:
  - When m_cyc_i & m_stb_i, latch adr, dat, we, sel, the winning slave index and the unmapped flag.
  - Mapped access: go to BUSY.
  - Unmapped access: go directly to RESP with err (UNMAPPED_ERR=1), or with ack and m_dat_o=DEFAULT_DATA (UNMAPPED_ERR=0).
- BUSY:
  - s_stb_o[idx] and s_cyc_o[idx] are 1; all other slaves' stb and cyc are 0.
  - Latched adr, dat, we and sel are broadcast to all slaves.
  - The timeout counter increments every cycle from 0.
- Leaving BUSY to RESP, sampled at the clock edge:
  - s_err_i[idx] → err.
  - Otherwise s_ack_i[idx] → ack, capturing s_dat_i[idx] into m_dat_o.
  - Otherwise s_rty_i[idx] → rty.
  - Otherwise counter == TIMEOUT-1 → err, with a timeout_o pulse in the RESP cycle.
  - Priority is err > ack > rty > timeout.
- Abort: if m_cyc_i=0 in BUSY, return to IDLE next edge, drop slave stb/cyc, and give no master response.
- RESP:
  - Exactly one of m_ack_o, m_err_o, m_rty_o is high, for exactly one cycle.
  - All slave stb/cyc are 0.
  - Next state is always IDLE; a request still present in RESP is not re-accepted until IDLE.
- Latency: request seen at edge E0, zero-wait slave acks in the cycle after E0, m_ack_o is high between E1 and E2. Unmapped requests respond between E0 and E1.
- m_dat_o holds its last captured value outside RESP; writes do not update it.
- err_count_o increments on every RESP carrying err (including timeout and unmapped) and saturates at 16'hffff.
- Reset, synchronous, takes effect even mid-transaction:
  - State goes to IDLE.
  - All m_* and s_* outputs go to 0, as do timeout_o, the counter and err_count_o.
  - Latched registers are cleared.

Test Plan:
- Six slaves configured as in the SoC map (GPIO 0x200/-4, memory at the reset vector, and so on). Read 0x200; GPIO acks on its first BUSY cycle with 0x00ABCDEF → s_stb_o[GPIO] high exactly 1 cycle; m_ack_o high 2 edges after the request; m_dat_o=0x00ABCDEF.
- Write to an address matched by two slaves → only the lowest index gets stb; the others stay at 0.
- Unmapped read with UNMAPPED_ERR=1 → m_err_o after 1 edge; err_count_o=1. Repeat with UNMAPPED_ERR=0 → m_ack_o with m_dat_o=0xffffffff; err_count_o unchanged.
- Selected slave never responds, TIMEOUT=4 → slave stb high 4 cycles; then m_err_o and timeout_o each pulse 1 cycle.
- Slave asserts ack and err together → m_err_o only. Slave asserts rty only → m_rty_o only.
- Drop m_cyc_i mid-BUSY → no master response, slave stb low next cycle. Assert reset mid-BUSY → all outputs 0 on the following cycle, state IDLE, err_count_o=0.
